fifo_burst_drain: RTL and testbench



---
 rtl/fifo_burst_drain_pkg.sv | 23 ++
 rtl/fifo_burst_drain_stream_out_reg.sv | 41 ++++
 rtl/fifo_burst_drain.sv | 132 +++++++++++++
 tb/tb_fifo_burst_drain.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_drain_pkg.sv
// Shared types and sizing helpers for the FIFO burst-drain read path.
// The state encoding is fixed so that debug tooling can decode it.
package fifo_burst_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int DEF_BURST_LEN = 16;
  localparam int DEF_TIMEOUT   = 64;

  // Counter widths must hold the terminal value n-1; never return less than 1 bit
  function automatic int beat_cnt_w(input int burst_len);
    return (burst_len < 2) ? 1 : $clog2(burst_len);
  endfunction

  function automatic int to_cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/fifo_burst_drain_stream_out_reg.sv
// Registered stream output stage: holds data/last while the consumer stalls.
// o_can_load tells the producer a new beat may be written this cycle.
module stream_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_can_load
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_last     = r_last;
  assign o_can_load = !r_valid || i_ready;

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains the line-buffer FIFO into framed downstream bursts; partial data left
// idle for TIMEOUT cycles is flushed as single-beat bursts.
module fifo_burst_drain
  import fifo_burst_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_fifo_valid,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_almostempty,
  output logic                  o_fifo_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_flush,
  output logic [CNT_WIDTH-1:0]  o_burst_count
);

  localparam int BEAT_W = beat_cnt_w(BURST_LEN);
  localparam int TO_W   = to_cnt_w(TIMEOUT);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  state_e               r_state;
  logic [BEAT_W-1:0]    r_beat_cnt;
  logic [TO_W-1:0]      r_to_cnt;
  logic [CNT_WIDTH-1:0] r_burst_count;

  state_e               w_state_nxt;
  logic [BEAT_W-1:0]    w_beat_nxt;
  logic [TO_W-1:0]      w_to_nxt;
  logic                 w_fifo_ready;
  logic                 w_last;
  logic                 w_can_load;
  logic                 w_read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_beat_cnt    <= '0;
      r_to_cnt      <= '0;
      r_burst_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_to_cnt   <= w_to_nxt;
      if (o_valid && i_ready && o_last)
        r_burst_count <= r_burst_count + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat_cnt;
    w_to_nxt     = r_to_cnt;
    w_fifo_ready = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_fifo_almostempty) begin
          w_state_nxt = ST_BURST;
          w_beat_nxt  = '0;
          w_to_nxt    = '0;
        end else if (i_fifo_valid) begin
          if (r_to_cnt == TO_LAST) begin
            w_state_nxt = ST_FLUSH;
            w_to_nxt    = '0;
          end else begin
            w_to_nxt = r_to_cnt + TO_W'(1);
          end
        end else begin
          w_to_nxt = '0;
        end
      end
      ST_BURST: begin
        // Starvation simply stalls here; a burst only ends on its final beat
        w_fifo_ready = w_can_load;
        w_last       = (r_beat_cnt == BEAT_LAST);
        if (w_can_load && i_fifo_valid) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat_cnt + BEAT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        w_last = 1'b1;
        // No read on the cycle we hand over to a full burst
        w_fifo_ready = w_can_load && !(i_fifo_valid && !i_fifo_almostempty);
        if (!i_fifo_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (!i_fifo_almostempty) begin
          w_state_nxt = ST_BURST;
          w_beat_nxt  = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_read = w_fifo_ready && i_fifo_valid;

  stream_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_read),
    .i_data    (i_fifo_data),
    .i_last    (w_last),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_last    (o_last),
    .o_can_load(w_can_load)
  );

  assign o_fifo_ready  = w_fifo_ready;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_flush       = (r_state == ST_FLUSH);
  assign o_burst_count = r_burst_count;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: a queue-modelled show-ahead FIFO feeds the DUT,
// and a negedge monitor scores every downstream beat against expected beats.
module tb_fifo_burst_drain;

  localparam int DW = 8;
  localparam int BL = 16;
  localparam int TO = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_fifo_valid;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_almostempty;
  logic          o_fifo_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          i_ready;
  logic          o_busy;
  logic          o_flush;
  logic [CW-1:0] o_burst_count;

  logic [DW-1:0] fifo_q[$];
  logic [DW:0]   exp_q[$];
  bit            starve;
  int            rd_count;
  int            n_checks;
  int            n_pass;

  fifo_burst_drain #(
    .DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_fifo_valid      (i_fifo_valid),
    .i_fifo_data       (i_fifo_data),
    .i_fifo_almostempty(i_fifo_almostempty),
    .o_fifo_ready      (o_fifo_ready),
    .o_valid           (o_valid),
    .o_data            (o_data),
    .o_last            (o_last),
    .i_ready           (i_ready),
    .o_busy            (o_busy),
    .o_flush           (o_flush),
    .o_burst_count     (o_burst_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic update_pins();
    if (starve || fifo_q.size() == 0) begin
      i_fifo_valid       = 1'b0;
      i_fifo_data        = '0;
      i_fifo_almostempty = 1'b1;
    end else begin
      i_fifo_valid       = 1'b1;
      i_fifo_data        = fifo_q[0];
      i_fifo_almostempty = (fifo_q.size() <= BL - 1);
    end
  endtask

  // One clock: sample the read request away from the edge, then retire it
  task automatic step();
    logic          rd;
    logic [DW-1:0] tmp;
    @(negedge clk);
    rd = o_fifo_ready && i_fifo_valid;
    @(posedge clk);
    #1;
    if (rd) begin
      tmp = fifo_q.pop_front();
      rd_count++;
    end
    update_pins();
  endtask

  task automatic push(input logic [DW-1:0] d, input bit last);
    fifo_q.push_back(d);
    exp_q.push_back({last, d});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    starve  = 1'b0;
    i_ready = 1'b1;
    update_pins();
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic drain(input string name, input int budget, input bit toggle);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      if (toggle) i_ready = ~i_ready;
      n++;
    end
    check(name, exp_q.size(), 0);
    i_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic wait_reads(input string name, input int target);
    int n;
    n = 0;
    while (rd_count < target && n < 200) begin
      step();
      n++;
    end
    check(name, rd_count, target);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [DW:0] e;
    if (reset_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL beat_extra: got last=%0d data=0x%0h expected no beat", o_last, o_data);
      end else begin
        e = exp_q.pop_front();
        check("beat", {23'd0, o_last, o_data}, {23'd0, e});
      end
    end
    if (reset_n && o_valid && !i_ready)
      check("bp_fifo_ready", {31'd0, o_fifo_ready}, 32'd0);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    n_checks = 0;
    n_pass   = 0;
    rd_count = 0;
    reset_n  = 1'b0;
    starve   = 1'b0;
    i_ready  = 1'b1;
    update_pins();
    #1;
    check("rst_o_valid", {31'd0, o_valid}, 0);
    check("rst_o_last", {31'd0, o_last}, 0);
    check("rst_o_data", {24'd0, o_data}, 0);
    check("rst_fifo_ready", {31'd0, o_fifo_ready}, 0);
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_flush", {31'd0, o_flush}, 0);
    check("rst_burst_count", {16'd0, o_burst_count}, 0);
    do_reset();

    // Full burst 0x00..0x0F, last only on 0x0F
    for (int i = 0; i < 16; i++) push(DW'(i), i == 15);
    update_pins();
    drain("t1_drain", 100, 1'b0);
    check("t1_burst_count", {16'd0, o_burst_count}, 1);
    check("t1_idle", {31'd0, o_busy}, 0);

    // Reset asserted at beat 7 of a burst (count was 1)
    for (int i = 0; i < 16; i++) push(DW'(8'h50 + i), i == 15);
    update_pins();
    base = rd_count;
    wait_reads("t6_reach_beat7", base + 7);
    reset_n = 1'b0;
    #1;
    check("t6_valid_drop", {31'd0, o_valid}, 0);
    check("t6_ready_drop", {31'd0, o_fifo_ready}, 0);
    fifo_q.delete();
    exp_q.delete();
    update_pins();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    check("t6_burst_count", {16'd0, o_burst_count}, 0);
    check("t6_idle", {31'd0, o_busy}, 0);

    // Timeout flush of 3 partial entries
    do_reset();
    for (int i = 0; i < 3; i++) push(DW'(8'hA0 + i), 1'b1);
    update_pins();
    base = rd_count;
    repeat (63) step();
    check("t2_no_early_read", rd_count, base);
    check("t2_not_flush_63", {31'd0, o_flush}, 0);
    step();
    check("t2_flush_64", {31'd0, o_flush}, 1);
    drain("t2_drain", 50, 1'b0);
    check("t2_burst_count", {16'd0, o_burst_count}, 3);
    check("t2_idle", {31'd0, o_busy}, 0);

    // Full burst with downstream ready toggling every cycle
    do_reset();
    for (int i = 0; i < 16; i++) push(DW'(i), i == 15);
    update_pins();
    drain("t3_drain", 200, 1'b1);
    check("t3_burst_count", {16'd0, o_burst_count}, 1);

    // Refill during FLUSH: one flushed beat, then a 16-beat burst, then timeout flush of 2
    do_reset();
    push(8'hA0, 1'b1);
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    update_pins();
    repeat (64) step();
    check("t4_in_flush", {31'd0, o_flush}, 1);
    step();
    for (int i = 0; i < 16; i++) push(DW'(8'h10 + i), i >= 13);
    update_pins();
    #1;
    check("t4_no_read_on_switch", {31'd0, o_fifo_ready}, 0);
    base = rd_count;
    step();
    check("t4_switch_no_read", rd_count, base);
    check("t4_burst_state", {30'd0, o_flush, o_busy}, 32'd1);
    drain("t4_drain", 300, 1'b0);
    check("t4_burst_count", {16'd0, o_burst_count}, 4);

    // Starvation after 5 beats for 100 cycles: burst must stall, not end
    do_reset();
    for (int i = 0; i < 16; i++) push(DW'(8'h30 + i), i == 15);
    update_pins();
    base = rd_count;
    wait_reads("t5_reach_beat5", base + 5);
    starve = 1'b1;
    update_pins();
    repeat (100) step();
    check("t5_still_busy", {31'd0, o_busy}, 1);
    check("t5_not_flush", {31'd0, o_flush}, 0);
    check("t5_no_output", {31'd0, o_valid}, 0);
    check("t5_count_held", {16'd0, o_burst_count}, 0);
    starve = 1'b0;
    update_pins();
    drain("t5_drain", 100, 1'b0);
    check("t5_burst_count", {16'd0, o_burst_count}, 1);
    check("t5_idle", {31'd0, o_busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
